sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 mem_addr  output  16  memory word address.
REQ-004 mem_rd  output  1  read request.
REQ-005 mem_wr  output  1  write request.
REQ-006 mem_wdata  output  16  write data.
REQ-007 mem_rdata  input  16  read data, valid when mem_ready=1.
REQ-008 mem_ready  input  1  completes the current request at the sampling edge.
REQ-009 src_sel  output  3  register-file source/read select.
REQ-010 dst_sel  output  3  register-file destination/write select.
REQ-011 in_en  output  1  register-file write enable.
REQ-012 in  output  16  register-file write data.
REQ-013 pc_inc  output  1  register-file r0 (PC) increment strobe.
REQ-014 src  input  16  register-file value at src_sel.
REQ-015 dst  input  16  register-file value at dst_sel.
REQ-016 halted  output  1  high while in HALT.
REQ-017 ir  output  16  current instruction register.

Function
REQ-018 Instruction format SHALL be: op=ir[15:12], rd=ir[11:9], rs=ir[8:6], imm8=ir[7:0].
REQ-019 Opcodes SHALL be: 0 NOP; 1 MOV rd<=rs; 2 LDI rd<=zext(imm8); 3 LD rd<=mem[rs]; 4 ST mem[rd]<=rs; 5 ADD; 6 SUB; 7 AND; 8 OR; 9 XOR (rd<=rd op rs); A JMP r0<=rs; B JZ if rd==0 then r0<=rs; C-E treated as NOP; F HLT.
REQ-020 Arithmetic SHALL be 16-bit modulo 2^16; carry and borrow discarded; no flags.
REQ-021 States SHALL be IDLE, FETCH, EXEC, MEM, BRANCH, HALT.
REQ-022 IDLE: all strobes 0; next state FETCH.
REQ-023 FETCH: src_sel=0, mem_rd=1, mem_addr=src; hold until mem_ready=1; on that edge ir<=mem_rdata, state<=EXEC; pc_inc=1 combinationally in exactly that cycle.
REQ-024 EXEC (1 cycle): src_sel=rs, dst_sel=rd (forced 0 for JMP); ALU/MOV/LDI/JMP assert in_en=1 with result on in, then FETCH.
REQ-025 EXEC: LD, ST -> MEM; JZ with dst==0 -> BRANCH, else FETCH; NOP and reserved -> FETCH; HLT -> HALT.
REQ-026 MEM for LD: mem_rd=1, mem_addr=src (rs); on mem_ready in_en=1, in=mem_rdata, dst_sel=rd, then FETCH.
REQ-027 MEM for ST: mem_wr=1, mem_addr=dst (rd), mem_wdata=src (rs); on mem_ready go to FETCH; no register write.
REQ-028 BRANCH (1 cycle): dst_sel=0, src_sel=rs, in=src, in_en=1, then FETCH.
REQ-029 Request outputs SHALL stay constant while waiting; mem_ready is ignored when no request is active; a zero-wait response (ready in the first request cycle) SHALL be accepted.
REQ-030 mem_rd and mem_wr SHALL never be high together; in_en and pc_inc SHALL never be high together.
REQ-031 HALT SHALL persist (halted=1, all strobes 0) until reset.
REQ-032 A write to r0 by MOV/ALU/LDI/LD SHALL act as a jump.

Reset
REQ-033 On rst, state SHALL be IDLE and ir=0x0000 immediately; all strobes and halted 0.
REQ-034 Reset mid-request SHALL abandon the request without a register write.

Structure
REQ-035 Package tiny16_pkg SHALL hold opcode constants, the state enumeration and field-position constants.
REQ-036 A combinational sub-module alu SHALL compute MOV/ADD/SUB/AND/OR/XOR; the FSM stays in sequencer.

Verification
REQ-037 Reset, then mem holds 0x245A at addr 0 -> one-cycle pc_inc, then in_en=1, dst_sel=2, in=0x005A.
REQ-038 r2=0x005A, r3=0xFFB0, fetch 0x5680 (ADD r3,r2) -> in=0x000A, dst_sel=3.
REQ-039 r3=0x0100, r2=0x005A, fetch 0x4680 (ST) with mem_ready delayed 3 cycles -> mem_wr held 4 cycles, addr 0x0100, wdata 0x005A.
REQ-040 r4=0, r2=0x0020, fetch 0xB880 (JZ) -> BRANCH cycle writes r0=0x0020; with r4=1 -> no write, next FETCH.
REQ-041 Fetch 0xF000 -> halted=1, no further mem_rd; rst asserted mid-LD wait -> strobes drop immediately.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 sequencer: instruction fields, opcodes,
// FSM state encoding and small field-extraction helpers.
package tiny16_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] ir_rd(input logic [15:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [2:0] ir_rs(input logic [15:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [7:0] ir_imm8(input logic [15:0] ir);
    return ir[IMM_MSB:IMM_LSB];
  endfunction

  // Opcodes whose EXEC result comes from the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Memory bus and register-file port bundle between the sequencer (master)
// and the memory/register-file side (slave).
interface sequencer_if;

  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic        in_en;
  logic [15:0] in;
  logic        pc_inc;
  logic [15:0] src;
  logic [15:0] dst;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready,
    output src_sel, dst_sel, in_en, in, pc_inc,
    input  src, dst
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready,
    input  src_sel, dst_sel, in_en, in, pc_inc,
    output src, dst
  );

endinterface

// File: rtl/sequencer_alu.sv
// Combinational datapath for MOV and the two-operand ALU instructions;
// a is the destination register value, b the source register value.
module alu
  import tiny16_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_MOV:  y = b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/sequencer.sv
// tiny16 instruction sequencer: fetches from memory, decodes and drives the
// external register file; r0 is the program counter.
//
//   state  | meaning
//   IDLE   | post-reset, one quiet cycle before the first fetch
//   FETCH  | read mem[r0]; on ready latch ir and pulse pc_inc
//   EXEC   | decode; register-only ops write back here
//   MEM    | LD/ST data transfer, held until mem_ready
//   BRANCH | taken JZ: r0 <= rs
//   HALT   | stopped until reset
module sequencer
  import tiny16_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sequencer_if.master  bus,
  output logic         halted,
  output logic [15:0]  ir
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  imm8;
  logic [15:0] alu_y;

  assign op   = ir_op(ir);
  assign rd   = ir_rd(ir);
  assign rs   = ir_rs(ir);
  assign imm8 = ir_imm8(ir);

  alu u_alu (
    .op (op),
    .a  (bus.dst),
    .b  (bus.src),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.mem_ready)
        ir <= bus.mem_rdata;
    end
  end

  // All strobes are decoded from state alone, so reset drops them at once.
  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    bus.src_sel   = '0;
    bus.dst_sel   = '0;
    bus.in_en     = 1'b0;
    bus.in        = '0;
    bus.pc_inc    = 1'b0;
    halted        = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        bus.src_sel  = 3'd0;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = bus.src;
        if (bus.mem_ready) begin
          bus.pc_inc = 1'b1;
          state_nxt  = S_EXEC;
        end
      end

      S_EXEC: begin
        bus.src_sel = rs;
        bus.dst_sel = (op == OP_JMP) ? 3'd0 : rd;
        state_nxt   = S_FETCH;
        if (is_alu_op(op)) begin
          bus.in_en = 1'b1;
          bus.in    = alu_y;
        end else begin
          case (op)
            OP_LDI: begin
              bus.in_en = 1'b1;
              bus.in    = {8'h00, imm8};
            end
            OP_JMP: begin
              bus.in_en = 1'b1;
              bus.in    = bus.src;
            end
            OP_LD, OP_ST: state_nxt = S_MEM;
            OP_JZ:        state_nxt = (bus.dst == 16'h0000) ? S_BRANCH : S_FETCH;
            OP_HLT:       state_nxt = S_HALT;
            default:      state_nxt = S_FETCH;
          endcase
        end
      end

      S_MEM: begin
        bus.src_sel = rs;
        bus.dst_sel = rd;
        if (op == OP_LD) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = bus.src;
          if (bus.mem_ready) begin
            bus.in_en = 1'b1;
            bus.in    = bus.mem_rdata;
            state_nxt = S_FETCH;
          end
        end else begin
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = bus.dst;
          bus.mem_wdata = bus.src;
          if (bus.mem_ready)
            state_nxt = S_FETCH;
        end
      end

      S_BRANCH: begin
        bus.dst_sel = 3'd0;
        bus.src_sel = rs;
        bus.in      = bus.src;
        bus.in_en   = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sequencer.sv
// Scoreboard bench for the tiny16 sequencer with a behavioural register file
// and memory whose ready latency is programmable per program.
module tb_sequencer;
  import tiny16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [15:0] ir;

  sequencer_if bus();

  sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.master),
    .halted (halted),
    .ir     (ir)
  );

  always #5 clk = ~clk;

  logic [15:0] rf[8];
  logic [15:0] init_rf[8];
  logic [15:0] mem[1024];
  logic [15:0] init_mem[1024];
  int          ready_delay = 0;
  logic        idle_ready = 1'b0;
  int          wait_cnt;
  logic        req;

  assign req           = bus.mem_rd | bus.mem_wr;
  assign bus.mem_ready = req ? (wait_cnt == ready_delay) : idle_ready;
  assign bus.src       = rf[bus.src_sel];
  assign bus.dst       = rf[bus.dst_sel];
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rf       <= init_rf;
      mem      <= init_mem;
      wait_cnt <= 0;
    end else begin
      if (bus.pc_inc) rf[0] <= rf[0] + 16'd1;
      if (bus.in_en) rf[bus.dst_sel] <= bus.in;
      if (bus.mem_wr && bus.mem_ready) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      wait_cnt <= (req && !bus.mem_ready) ? wait_cnt + 1 : 0;
    end
  end

  typedef struct {
    bit          is_st;
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pc_cnt = 0;
  int   wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [2:0] sel, input logic [15:0] data);
    exp_t e;
    e.is_st = 1'b0; e.sel = sel; e.addr = '0; e.data = data;
    expq.push_back(e);
  endtask

  task automatic exp_st(input logic [15:0] addr, input logic [15:0] data);
    exp_t e;
    e.is_st = 1'b1; e.sel = '0; e.addr = addr; e.data = data;
    expq.push_back(e);
  endtask

  task automatic monitor();
    logic        prev_wait = 1'b0;
    logic [31:0] prev_req  = '0;
    logic [31:0] cur;
    exp_t        e;
    forever begin
      @(negedge clk);
      cur = {14'd0, bus.mem_rd, bus.mem_wr, bus.mem_addr};
      if (!rst) begin
        if (bus.pc_inc) pc_cnt++;
        if (bus.mem_wr) wr_cyc++;
        if (bus.mem_rd && bus.mem_wr) check("rd_wr_exclusive", 1, 0);
        if (bus.in_en && bus.pc_inc) check("en_inc_exclusive", 1, 0);
        if (prev_wait) check("req_hold", cur, prev_req);
        if (bus.in_en) begin
          if (expq.size() == 0) check("unexpected_write", {13'd0, bus.dst_sel, bus.in}, 0);
          else begin
            e = expq.pop_front();
            check("wr_kind", 32'(bus.in_en && !e.is_st), 1);
            check("wr_sel", bus.dst_sel, e.sel);
            check("wr_data", bus.in, e.data);
          end
        end
        if (bus.mem_wr && bus.mem_ready) begin
          if (expq.size() == 0) check("unexpected_store", bus.mem_addr, 0);
          else begin
            e = expq.pop_front();
            check("st_kind", 32'(e.is_st), 1);
            check("st_addr", bus.mem_addr, e.addr);
            check("st_data", bus.mem_wdata, e.data);
          end
        end
      end
      prev_wait = !rst && req && !bus.mem_ready;
      prev_req  = cur;
    end
  endtask

  task automatic clear_init();
    expq.delete();
    for (int i = 0; i < 8; i++) init_rf[i] = '0;
    for (int i = 0; i < 1024; i++) init_mem[i] = '0;
  endtask

  task automatic start_test(input int dly, input logic idl);
    rst = 1'b1;
    ready_delay = dly;
    idle_ready = idl;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", ir, 16'h0000);
    check("rst_strobes", {bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, halted}, 0);
    @(negedge clk);
    pc_cnt = 0;
    wr_cyc = 0;
    rst = 1'b0;
  endtask

  task automatic finish_prog(input int fetches);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_halt", halted, 1);
    check("queue_drained", expq.size(), 0);
    check("fetch_count", pc_cnt, fetches);
    repeat (3) begin
      @(negedge clk);
      check("halt_quiet", {bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, halted}, 5'b00001);
    end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // LDI, then ALU/MOV chain on r3/r2, reserved opcodes, halt; zero-wait memory.
    clear_init();
    init_rf[3]  = 16'hFFB0;
    init_mem[0] = 16'h245A;
    init_mem[1] = 16'h5680;
    init_mem[2] = 16'h6680;
    init_mem[3] = 16'h7680;
    init_mem[4] = 16'h8680;
    init_mem[5] = 16'h9680;
    init_mem[6] = 16'h1280;
    init_mem[7] = 16'h0000;
    init_mem[8] = 16'hC123;
    init_mem[9] = 16'hF000;
    exp_wr(3'd2, 16'h005A);
    exp_wr(3'd3, 16'h000A);
    exp_wr(3'd3, 16'hFFB0);
    exp_wr(3'd3, 16'h0010);
    exp_wr(3'd3, 16'h005A);
    exp_wr(3'd3, 16'h0000);
    exp_wr(3'd1, 16'h005A);
    start_test(0, 1'b0);
    finish_prog(10);

    // ST with three wait cycles, then LD of the stored word.
    clear_init();
    init_rf[3]  = 16'h0100;
    init_rf[2]  = 16'h005A;
    init_mem[0] = 16'h4680;
    init_mem[1] = 16'h3AC0;
    init_mem[2] = 16'hF000;
    exp_st(16'h0100, 16'h005A);
    exp_wr(3'd5, 16'h005A);
    start_test(3, 1'b0);
    finish_prog(3);
    check("st_wr_cycles", wr_cyc, 4);

    // JZ taken and not taken, JMP with nonzero rd field, LDI into r0.
    clear_init();
    init_rf[2]     = 16'h0020;
    init_rf[6]     = 16'h0040;
    init_mem[0]    = 16'hB880;
    init_mem[16'h20] = 16'h2801;
    init_mem[16'h21] = 16'hB880;
    init_mem[16'h22] = 16'hAF80;
    init_mem[16'h40] = 16'h2050;
    init_mem[16'h50] = 16'hF000;
    exp_wr(3'd0, 16'h0020);
    exp_wr(3'd4, 16'h0001);
    exp_wr(3'd0, 16'h0040);
    exp_wr(3'd0, 16'h0050);
    start_test(0, 1'b1);
    finish_prog(6);

    // Reset asserted while an LD waits for memory.
    clear_init();
    init_rf[3]       = 16'h0010;
    init_mem[0]      = 16'h3AC0;
    init_mem[16'h10] = 16'h1234;
    start_test(5, 1'b0);
    n = 0;
    while (!(bus.mem_rd && ir == 16'h3AC0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ld_wait_seen", 32'(bus.mem_rd && ir == 16'h3AC0), 1);
    check("ld_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreq_strobes", {bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, halted}, 0);
    check("midreq_ir", ir, 16'h0000);
    repeat (2) @(negedge clk);
    check("midreq_no_write", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
